// File: rtl/accel_ball_bounce.sv
// accel_ball_bounce: accelerometer-driven bouncing sprites. Each physics tick the balls
// are integrated one per cycle through a shared datapath, then published together.

module accel_ball_axis #(
    parameter int ACCEL_WIDTH = 8,
    parameter int VEL_BITS    = 16,
    parameter int POS_BITS    = 19,
    parameter int DAMP_SHIFT  = 2,
    parameter int LIM         = 0
) (
    input  logic signed [POS_BITS-1:0]    pos,
    input  logic signed [VEL_BITS-1:0]    vel,
    input  logic signed [ACCEL_WIDTH-1:0] accel,
    output logic signed [POS_BITS-1:0]    pos_next,
    output logic signed [VEL_BITS-1:0]    vel_next,
    output logic                          bounce
);
    localparam int VW = ((VEL_BITS > ACCEL_WIDTH) ? VEL_BITS : ACCEL_WIDTH) + 1;
    localparam int SW = ((POS_BITS > VEL_BITS) ? POS_BITS : VEL_BITS) + 1;
    // Symmetric clamp: the most negative code is never produced, so negation is safe.
    localparam logic signed [VW-1:0] VMAX = VW'($signed({1'b0, {(VEL_BITS-1){1'b1}}}));

    logic signed [VW-1:0]       vsum;
    logic signed [VEL_BITS-1:0] vsat;
    logic signed [VEL_BITS-1:0] vdamp;
    logic signed [SW-1:0]       psum;

    always_comb begin
        vsum = VW'(vel) + VW'(accel);
        if (vsum > VMAX)
            vsat = VEL_BITS'(VMAX);
        else if (vsum < -VMAX)
            vsat = VEL_BITS'(-VMAX);
        else
            vsat = VEL_BITS'(vsum);

        psum     = SW'(pos) + SW'(vsat);
        vdamp    = vsat - (vsat >>> DAMP_SHIFT);
        pos_next = POS_BITS'(psum);
        vel_next = vsat;
        bounce   = 1'b0;

        if (psum < 0) begin
            pos_next = '0;
            vel_next = -vdamp;
            bounce   = 1'b1;
        end else if (psum > SW'(LIM)) begin
            pos_next = POS_BITS'(LIM);
            vel_next = -vdamp;
            bounce   = 1'b1;
        end
    end
endmodule

module accel_ball_bounce #(
    parameter int NUM_BALLS     = 2,
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 180,
    parameter int SPRITE_SIZE   = 32,
    parameter int ACCEL_WIDTH   = 8,
    parameter int FRAC_BITS     = 8,
    parameter int VEL_BITS      = 16,
    parameter int TICK_DIV      = 35000,
    parameter int DAMP_SHIFT    = 2
) (
    input  logic                          CLK,
    input  logic                          rst,
    input  logic                          i_enable,
    input  logic                          i_load,
    input  logic signed [ACCEL_WIDTH-1:0] i_accel_x,
    input  logic signed [ACCEL_WIDTH-1:0] i_accel_y,
    input  logic [10*NUM_BALLS-1:0]       i_init_x,
    input  logic [10*NUM_BALLS-1:0]       i_init_y,
    output logic [10*NUM_BALLS-1:0]       o_pos_x,
    output logic [10*NUM_BALLS-1:0]       o_pos_y,
    output logic [NUM_BALLS-1:0]          o_bounce_x,
    output logic [NUM_BALLS-1:0]          o_bounce_y,
    output logic                          o_update_done,
    output logic                          o_overrun
);
    localparam int PB    = 10 + FRAC_BITS + 1;
    localparam int IW    = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
    localparam int CW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LIM_X = (SCREEN_WIDTH - SPRITE_SIZE) << FRAC_BITS;
    localparam int LIM_Y = (SCREEN_HEIGHT - SPRITE_SIZE) << FRAC_BITS;
    localparam logic [IW-1:0] LAST    = IW'(NUM_BALLS - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]                      tick_cnt;
    logic                               tick;
    logic [IW-1:0]                      idx;
    logic [NUM_BALLS-1:0][PB-1:0]       pos_x, pos_y;
    logic [NUM_BALLS-1:0][VEL_BITS-1:0] vel_x, vel_y;
    logic [NUM_BALLS-1:0]               hit_x, hit_y;
    logic signed [PB-1:0]               px_nxt, py_nxt;
    logic signed [VEL_BITS-1:0]         vx_nxt, vy_nxt;
    logic                               bx_nxt, by_nxt;

    // Tick counter runs only while the game is enabled; load leaves it alone.
    always_ff @(posedge CLK) begin
        if (rst)
            tick_cnt <= '0;
        else if (i_enable)
            tick_cnt <= (tick_cnt == CNT_MAX) ? '0 : tick_cnt + 1'b1;
    end

    assign tick = i_enable && (tick_cnt == CNT_MAX);

    always_ff @(posedge CLK) begin
        if (rst || i_load)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick) state_nxt = CALC;
            CALC:    if (idx == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst || i_load || state != CALC)
            idx <= '0;
        else
            idx <= idx + 1'b1;
    end

    accel_ball_axis #(
        .ACCEL_WIDTH(ACCEL_WIDTH), .VEL_BITS(VEL_BITS), .POS_BITS(PB),
        .DAMP_SHIFT(DAMP_SHIFT), .LIM(LIM_X)
    ) u_axis_x (
        .pos(pos_x[idx]), .vel(vel_x[idx]), .accel(i_accel_x),
        .pos_next(px_nxt), .vel_next(vx_nxt), .bounce(bx_nxt)
    );

    accel_ball_axis #(
        .ACCEL_WIDTH(ACCEL_WIDTH), .VEL_BITS(VEL_BITS), .POS_BITS(PB),
        .DAMP_SHIFT(DAMP_SHIFT), .LIM(LIM_Y)
    ) u_axis_y (
        .pos(pos_y[idx]), .vel(vel_y[idx]), .accel(i_accel_y),
        .pos_next(py_nxt), .vel_next(vy_nxt), .bounce(by_nxt)
    );

    // Ball state updates during CALC; visible outputs only change on leaving DONE.
    always_ff @(posedge CLK) begin
        if (rst || i_load) begin
            for (int k = 0; k < NUM_BALLS; k++) begin
                pos_x[k] <= {1'b0, i_init_x[10*k +: 10], {FRAC_BITS{1'b0}}};
                pos_y[k] <= {1'b0, i_init_y[10*k +: 10], {FRAC_BITS{1'b0}}};
                vel_x[k] <= '0;
                vel_y[k] <= '0;
            end
            hit_x         <= '0;
            hit_y         <= '0;
            o_pos_x       <= i_init_x;
            o_pos_y       <= i_init_y;
            o_bounce_x    <= '0;
            o_bounce_y    <= '0;
            o_update_done <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            o_bounce_x    <= '0;
            o_bounce_y    <= '0;
            o_update_done <= 1'b0;
            o_overrun     <= tick && (state != IDLE);

            if (state == CALC) begin
                pos_x[idx] <= px_nxt;
                pos_y[idx] <= py_nxt;
                vel_x[idx] <= vx_nxt;
                vel_y[idx] <= vy_nxt;
                hit_x[idx] <= bx_nxt;
                hit_y[idx] <= by_nxt;
            end

            if (state == DONE) begin
                for (int k = 0; k < NUM_BALLS; k++) begin
                    o_pos_x[10*k +: 10] <= pos_x[k][FRAC_BITS +: 10];
                    o_pos_y[10*k +: 10] <= pos_y[k][FRAC_BITS +: 10];
                end
                o_bounce_x    <= hit_x;
                o_bounce_y    <= hit_y;
                o_update_done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_accel_ball_bounce.sv
// Bench for accel_ball_bounce: scenario tasks against an integer physics model.
module tb_accel_ball_bounce;
    localparam int LIMX = 288 * 256;
    localparam int LIMY = 148 * 256;

    logic              CLK = 1'b0;
    logic              rst, en, en_ov, load;
    logic signed [7:0] ax, ay;
    logic [19:0]       init_x, init_y;
    logic [19:0]       pos_x, pos_y, pos_x2, pos_y2;
    logic [1:0]        bx, by, bx2, by2;
    logic              done, ovr, done2, ovr2;

    int n_cmp = 0;
    int n_err = 0;
    int kcnt  = 0;
    int mpx[2], mvx[2], mpy[2], mvy[2];
    bit mbx[2], mby[2];

    always #5 CLK = ~CLK;

    accel_ball_bounce #(
        .NUM_BALLS(2), .SCREEN_WIDTH(320), .SCREEN_HEIGHT(180), .SPRITE_SIZE(32),
        .ACCEL_WIDTH(8), .FRAC_BITS(8), .VEL_BITS(16), .TICK_DIV(8), .DAMP_SHIFT(2)
    ) dut (
        .CLK(CLK), .rst(rst), .i_enable(en), .i_load(load),
        .i_accel_x(ax), .i_accel_y(ay), .i_init_x(init_x), .i_init_y(init_y),
        .o_pos_x(pos_x), .o_pos_y(pos_y), .o_bounce_x(bx), .o_bounce_y(by),
        .o_update_done(done), .o_overrun(ovr)
    );

    accel_ball_bounce #(
        .NUM_BALLS(2), .SCREEN_WIDTH(320), .SCREEN_HEIGHT(180), .SPRITE_SIZE(32),
        .ACCEL_WIDTH(8), .FRAC_BITS(8), .VEL_BITS(16), .TICK_DIV(3), .DAMP_SHIFT(2)
    ) dut_ov (
        .CLK(CLK), .rst(rst), .i_enable(en_ov), .i_load(load),
        .i_accel_x(ax), .i_accel_y(ay), .i_init_x(init_x), .i_init_y(init_y),
        .o_pos_x(pos_x2), .o_pos_y(pos_y2), .o_bounce_x(bx2), .o_bounce_y(by2),
        .o_update_done(done2), .o_overrun(ovr2)
    );

    // One axis of one ball for one tick, straight from the motion rules.
    function automatic void axis_step(input int p, input int v, input int a, input int lim,
                                      output int np, output int nv, output bit b);
        int vs, ps;
        vs = v + a;
        if (vs > 32767) vs = 32767;
        if (vs < -32767) vs = -32767;
        ps = p + vs;
        if (ps < 0 || ps > lim) begin
            np = (ps < 0) ? 0 : lim;
            nv = -(vs - (vs >>> 2));
            b  = 1'b1;
        end else begin
            np = ps;
            nv = vs;
            b  = 1'b0;
        end
    endfunction

    task automatic model_tick();
        for (int b = 0; b < 2; b++) begin
            axis_step(mpx[b], mvx[b], int'(ax), LIMX, mpx[b], mvx[b], mbx[b]);
            axis_step(mpy[b], mvy[b], int'(ay), LIMY, mpy[b], mvy[b], mby[b]);
        end
    endtask

    task automatic model_load();
        for (int b = 0; b < 2; b++) begin
            mpx[b] = int'(init_x[10*b +: 10]) * 256;
            mpy[b] = int'(init_y[10*b +: 10]) * 256;
            mvx[b] = 0;
            mvy[b] = 0;
        end
    endtask

    function automatic logic [19:0] mpack(input int p0, input int p1);
        return {10'(p1 / 256), 10'(p0 / 256)};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
        if (en) kcnt++;
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            if (done) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; en_ov = 1'b0; load = 1'b0; ax = 8'sd0; ay = 8'sd0;
        init_x = {10'd10, 10'd100};
        init_y = {10'd20, 10'd50};
        repeat (3) @(posedge CLK);
        #1 rst = 1'b0;
        n_cmp++;
        if (pos_x !== init_x || pos_y !== init_y) begin
            n_err++;
            $display("FAIL reset_pos got x=%h y=%h exp x=%h y=%h", pos_x, pos_y, init_x, init_y);
        end
        n_cmp++;
        if ({bx, by, done, ovr} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_pulses got %b exp 000000", {bx, by, done, ovr});
        end
        n_cmp++;
        if (pos_x2 !== init_x || pos_y2 !== init_y) begin
            n_err++;
            $display("FAIL reset_pos_ov got x=%h y=%h exp x=%h y=%h", pos_x2, pos_y2, init_x, init_y);
        end
        ax = 8'sd50; ay = -8'sd50;
        for (int i = 0; i < 12; i++) begin
            step();
            n_cmp++;
            if (pos_x !== init_x || pos_y !== init_y || done !== 1'b0) begin
                n_err++;
                $display("FAIL hold_disabled cyc=%0d got x=%h y=%h done=%b exp x=%h y=%h done=0",
                         i, pos_x, pos_y, done, init_x, init_y);
            end
        end
    endtask

    task automatic test_gravity();
        int  ndone = 0;
        bit  exp_done;
        ax = 8'sd16; ay = 8'sd0;
        model_load();
        en = 1'b1;
        for (int j = 1; j <= 131; j++) begin
            step();
            exp_done = (kcnt >= 11) && (kcnt % 8 == 3);
            n_cmp++;
            if (done !== exp_done) begin
                n_err++;
                $display("FAIL gravity_done_timing cyc=%0d got %b exp %b", kcnt, done, exp_done);
            end
            if (done) begin
                ndone++;
                model_tick();
                n_cmp++;
                if (pos_x !== mpack(mpx[0], mpx[1]) || pos_y !== mpack(mpy[0], mpy[1]) ||
                    {by, bx} !== 4'b0) begin
                    n_err++;
                    $display("FAIL gravity_pos tick=%0d got x=%h y=%h b=%b exp x=%h y=%h b=0000",
                             ndone, pos_x, pos_y, {by, bx}, mpack(mpx[0], mpx[1]), mpack(mpy[0], mpy[1]));
                end
            end
        end
        n_cmp++;
        if (ndone != 16) begin
            n_err++;
            $display("FAIL gravity_done_count got %0d exp 16", ndone);
        end
        n_cmp++;
        if (pos_x[9:0] !== 10'd108 || pos_y[9:0] !== 10'd50) begin
            n_err++;
            $display("FAIL gravity_ball0 got (%0d,%0d) exp (108,50)", pos_x[9:0], pos_y[9:0]);
        end
    endtask

    task automatic test_wall_right();
        bit got;
        init_x = {10'd100, 10'd287};
        init_y = {10'd20, 10'd50};
        load = 1'b1; step(); load = 1'b0;
        model_load();
        n_cmp++;
        if (pos_x !== init_x || pos_y !== init_y || {bx, by, done} !== 5'b0) begin
            n_err++;
            $display("FAIL right_load got x=%h y=%h p=%b exp x=%h y=%h p=00000",
                     pos_x, pos_y, {bx, by, done}, init_x, init_y);
        end
        ax = 8'sd127; ay = 8'sd0;
        for (int t = 1; t <= 3; t++) begin
            if (t == 3) ax = 8'sd0;
            wait_done(20, got);
            n_cmp++;
            if (!got) begin
                n_err++;
                $display("FAIL right_timeout tick=%0d got no done exp done", t);
            end
            model_tick();
            n_cmp++;
            if (pos_x !== mpack(mpx[0], mpx[1]) || pos_y !== mpack(mpy[0], mpy[1]) ||
                bx !== {mbx[1], mbx[0]}) begin
                n_err++;
                $display("FAIL right_model tick=%0d got x=%h bx=%b exp x=%h bx=%b",
                         t, pos_x, bx, mpack(mpx[0], mpx[1]), {mbx[1], mbx[0]});
            end
            n_cmp++;
            if (pos_x[9:0] !== ((t == 2) ? 10'd288 : 10'd287) || bx[0] !== (t == 2)) begin
                n_err++;
                $display("FAIL right_ball0 tick=%0d got x=%0d bx0=%b exp x=%0d bx0=%b",
                         t, pos_x[9:0], bx[0], (t == 2) ? 288 : 287, (t == 2));
            end
        end
    endtask

    task automatic test_wall_left();
        bit got;
        init_x = {10'd0, 10'd150};
        init_y = {10'd20, 10'd50};
        load = 1'b1; step(); load = 1'b0;
        model_load();
        ax = -8'sd128; ay = 8'sd0;
        for (int t = 1; t <= 2; t++) begin
            if (t == 2) ax = 8'sd0;
            wait_done(20, got);
            n_cmp++;
            if (!got) begin
                n_err++;
                $display("FAIL left_timeout tick=%0d got no done exp done", t);
            end
            model_tick();
            n_cmp++;
            if (pos_x !== mpack(mpx[0], mpx[1]) || bx !== {mbx[1], mbx[0]}) begin
                n_err++;
                $display("FAIL left_model tick=%0d got x=%h bx=%b exp x=%h bx=%b",
                         t, pos_x, bx, mpack(mpx[0], mpx[1]), {mbx[1], mbx[0]});
            end
        end
        // Second tick: ball1 left the wall with +96 sub-pixels, still inside pixel 0.
        n_cmp++;
        if (pos_x !== {10'd0, 10'd149} || mvx[1] != 96) begin
            n_err++;
            $display("FAIL left_final got x=%h exp x=%h", pos_x, {10'd0, 10'd149});
        end
    endtask

    task automatic test_load_abort();
        bit got;
        int k0;
        ax = 8'($urandom_range(0, 255));
        ay = 8'($urandom_range(0, 255));
        for (int i = 0; i < 16 && (kcnt % 8) != 0; i++) step();
        init_x = {10'($urandom_range(0, 288)), 10'($urandom_range(0, 288))};
        init_y = {10'($urandom_range(0, 148)), 10'($urandom_range(0, 148))};
        load = 1'b1; step(); load = 1'b0;
        model_load();
        k0 = kcnt;
        n_cmp++;
        if (pos_x !== init_x || pos_y !== init_y || done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_load got x=%h y=%h done=%b exp x=%h y=%h done=0",
                     pos_x, pos_y, done, init_x, init_y);
        end
        wait_done(20, got);
        n_cmp++;
        if (!got || kcnt != k0 + 10) begin
            n_err++;
            $display("FAIL abort_done_cycle got cyc=%0d (seen=%b) exp cyc=%0d", kcnt, got, k0 + 10);
        end
        model_tick();
        n_cmp++;
        if (pos_x !== mpack(mpx[0], mpx[1]) || pos_y !== mpack(mpy[0], mpy[1])) begin
            n_err++;
            $display("FAIL abort_next_tick got x=%h y=%h exp x=%h y=%h",
                     pos_x, pos_y, mpack(mpx[0], mpx[1]), mpack(mpy[0], mpy[1]));
        end
    endtask

    task automatic test_random();
        bit got;
        for (int r = 0; r < 4; r++) begin
            init_x = {10'($urandom_range(0, 288)), 10'($urandom_range(0, 288))};
            init_y = {10'($urandom_range(0, 148)), 10'($urandom_range(0, 148))};
            load = 1'b1; step(); load = 1'b0;
            model_load();
            for (int t = 0; t < 6; t++) begin
                ax = 8'($urandom_range(0, 255));
                ay = 8'($urandom_range(0, 255));
                wait_done(20, got);
                n_cmp++;
                if (!got) begin
                    n_err++;
                    $display("FAIL random_timeout run=%0d tick=%0d got no done exp done", r, t);
                end
                model_tick();
                n_cmp++;
                if (pos_x !== mpack(mpx[0], mpx[1]) || pos_y !== mpack(mpy[0], mpy[1])) begin
                    n_err++;
                    $display("FAIL random_pos run=%0d tick=%0d got x=%h y=%h exp x=%h y=%h", r, t,
                             pos_x, pos_y, mpack(mpx[0], mpx[1]), mpack(mpy[0], mpy[1]));
                end
                n_cmp++;
                if ({by, bx, ovr} !== {mby[1], mby[0], mbx[1], mbx[0], 1'b0}) begin
                    n_err++;
                    $display("FAIL random_pulses run=%0d tick=%0d got %b exp %b", r, t,
                             {by, bx, ovr}, {mby[1], mby[0], mbx[1], mbx[0], 1'b0});
                end
            end
        end
    endtask

    task automatic test_overrun();
        int novr = 0;
        int ovr_at = -1;
        int done_at = -1;
        init_x = {10'($urandom_range(0, 288)), 10'($urandom_range(0, 288))};
        init_y = {10'($urandom_range(0, 148)), 10'($urandom_range(0, 148))};
        ax = 8'($urandom_range(0, 255));
        ay = 8'($urandom_range(0, 255));
        load = 1'b1; step(); load = 1'b0;
        model_load();
        en_ov = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            step();
            if (ovr2) begin novr++; ovr_at = j; end
            if (done2) done_at = j;
        end
        en_ov = 1'b0;
        n_cmp++;
        if (novr != 1 || ovr_at != 6) begin
            n_err++;
            $display("FAIL overrun_pulse got count=%0d at=%0d exp count=1 at=6", novr, ovr_at);
        end
        n_cmp++;
        if (done_at != 6) begin
            n_err++;
            $display("FAIL overrun_done got at=%0d exp at=6", done_at);
        end
        model_tick();
        n_cmp++;
        if (pos_x2 !== mpack(mpx[0], mpx[1]) || pos_y2 !== mpack(mpy[0], mpy[1])) begin
            n_err++;
            $display("FAIL overrun_pos got x=%h y=%h exp x=%h y=%h",
                     pos_x2, pos_y2, mpack(mpx[0], mpx[1]), mpack(mpy[0], mpy[1]));
        end
    endtask

    initial begin
        test_reset();
        test_gravity();
        test_wall_right();
        test_wall_left();
        test_load_abort();
        test_random();
        test_overrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/accel_ball_bounce.md
ACCEL_BALL_BOUNCE -- requirements
Module: accel_ball_bounce

Interface
REQ-001 Parameter NUM_BALLS, default 2: number of independent balls sharing one accelerometer input.
REQ-002 Parameter SCREEN_WIDTH, default 320; SCREEN_HEIGHT, default 180; SPRITE_SIZE, default 32; all in pixels.
REQ-003 Parameter ACCEL_WIDTH, default 8: signed accelerometer sample width.
REQ-004 Parameter FRAC_BITS, default 8: fractional bits of stored position.
REQ-005 Parameter VEL_BITS, default 16: signed velocity width, in units of 2^-FRAC_BITS px/tick.
REQ-006 Parameter TICK_DIV, default 35000: CLK cycles per physics tick; must be at least NUM_BALLS+3.
REQ-007 Parameter DAMP_SHIFT, default 2: bounce energy loss; 0 means the ball stops at the wall.
REQ-008 CLK  input  1  clock; all logic is on the rising edge.
REQ-009 rst  input  1  reset, synchronous, active-high.
REQ-010 i_enable  input  1  game playing; gates the tick counter.
REQ-011 i_load  input  1  reload initial positions and zero velocities.
REQ-012 i_accel_x, i_accel_y  input  ACCEL_WIDTH each  signed two's-complement acceleration, shared by all balls.
REQ-013 i_init_x, i_init_y  input  10*NUM_BALLS each  packed initial pixel positions; ball k occupies bits [10k+9:10k].
REQ-014 o_pos_x, o_pos_y  output  10*NUM_BALLS each  packed integer pixel positions, same packing.
REQ-015 o_bounce_x, o_bounce_y  output  NUM_BALLS each  one-cycle pulse per ball per wall hit on that axis.
REQ-016 o_update_done  output  1  one-cycle pulse when all outputs have been refreshed for a tick.
REQ-017 o_overrun  output  1  one-cycle pulse when a tick occurs while a calculation is still in progress.

Function
REQ-018 The tick counter SHALL increment while i_enable=1, hold while i_enable=0, and wrap from TICK_DIV-1 to 0; the tick event SHALL be the cycle in which it equals TICK_DIV-1.
REQ-019 The FSM SHALL use the states IDLE, CALC and DONE: IDLE->CALC on tick; in CALC it SHALL process ball index 0..NUM_BALLS-1, one ball per cycle; CALC->DONE after the last ball; DONE->IDLE after one cycle.
REQ-020 Per ball and per axis in CALC: v' = saturate(v + sign_extend(accel)) to ±(2^(VEL_BITS-1)-1); p' = p + sign_extend(v'); p is signed with 10+FRAC_BITS+1 bits.
REQ-021 If p' < 0: p=0, v = -(v' - (v' >>> DAMP_SHIFT)), and the bounce bit pulses.
REQ-022 If p' > LIM, where LIM = (SCREEN_WIDTH-SPRITE_SIZE)<<FRAC_BITS for x and (SCREEN_HEIGHT-SPRITE_SIZE)<<FRAC_BITS for y: p=LIM, v = -(v' - (v' >>> DAMP_SHIFT)), and the bounce bit pulses. If DAMP_SHIFT=0, v=0.
REQ-023 Otherwise the state SHALL take p=p' and v=v', with no pulse.
REQ-024 o_pos_*, o_bounce_* and o_update_done SHALL all update on the edge that leaves DONE, i.e. NUM_BALLS+2 edges after the tick edge, so that every ball moves in the same frame; between ticks, outputs hold and pulses are 0.
REQ-025 o_pos SHALL equal p >> FRAC_BITS, truncated toward minus infinity; since p >= 0, this is plain truncation.
REQ-026 A tick arriving in CALC or DONE SHALL be dropped and SHALL pulse o_overrun on the next edge.
REQ-027 i_load=1 SHALL, on the next edge: set p = i_init<<FRAC_BITS, set v=0, set o_pos = i_init, force the FSM to IDLE (aborting any CALC without asserting o_update_done), and clear the pulses. The tick counter SHALL be unaffected.
REQ-028 Deasserting i_enable mid-CALC SHALL NOT abort the current calculation.

Reset
REQ-029 rst SHALL take priority over i_load and i_enable.
REQ-030 On rst: counter=0, FSM=IDLE, all v=0, p = i_init<<FRAC_BITS, o_pos = i_init, all pulse outputs 0.

Verification
Parameters for all scenarios: NUM_BALLS=2, TICK_DIV=8, FRAC_BITS=8, VEL_BITS=16, DAMP_SHIFT=2, 320x180 screen, SPRITE_SIZE 32 (LIM x=288 px, y=148 px).
REQ-031 Reset with init ball0=(100,50) and ball1=(10,20) -> o_pos=(100,50),(10,20); no pulses; held while i_enable=0.
REQ-032 accel=(+16,0), enable, 16 ticks -> ball0 x=108, y=50; ball0 v_x=256; exactly 16 o_update_done pulses, each 4 edges after its tick.
REQ-033 Ball0 loaded at x=287, accel_x=+127 -> tick 1: x=287, no bounce; tick 2: x=288, o_bounce_x[0]=1, v_x=-191.
REQ-034 Ball1 at x=0, accel_x=-128 -> tick 1: x=0, o_bounce_x[1]=1, v_x=+96; ball0 is not affected by ball1's bounce.
REQ-035 i_load asserted in the first CALC cycle -> no o_update_done for that tick; o_pos = i_init on the next edge; the next tick proceeds normally from v=0.
REQ-036 Tick forced during CALC (TICK_DIV=3 override) -> o_overrun pulses once, and the in-progress update completes.
